// File: rtl/status_reporter_if.sv
// rtl/status_reporter_if.sv - byte-level handshake between status_reporter and the uart transmitter
interface status_reporter_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting;

  modport master (output transmit, output tx_byte, input is_transmitting);
  modport slave  (input transmit, input tx_byte, output is_transmitting);
endinterface

// File: rtl/status_reporter.sv
// rtl/status_reporter.sv - formats game status / game-over as 12-byte ASCII lines for the uart
module status_reporter #(
  parameter int CD_W      = 8,
  parameter int RATE_TICK = 10_000_000,
  parameter int GUARD     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                over,
  input  logic [15:0]         score,
  input  logic [CD_W-1:0]     count_down,
  status_reporter_if.master   uart,
  output logic                busy,
  output logic [15:0]         sent_count
);

  localparam int RW = $clog2(RATE_TICK + 1);
  localparam int CW = (CD_W > 10) ? CD_W : 10;
  localparam int GW = $clog2(GUARD + 1);
  localparam logic [RW-1:0] RATE_MAX = RW'(RATE_TICK);

  typedef enum logic [2:0] {IDLE, CONV, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t          state, next;
  logic            prev_over, over_pending, status_pending;
  logic [RW-1:0]   rate_cnt;
  logic [15:0]     last_score;
  logic [CD_W-1:0] last_cd;
  logic            line_over;
  logic [3:0]      idx;
  logic [9:0]      cd_work;
  logic [3:0]      h_dig, t_dig;
  logic [GW-1:0]   guard_cnt;
  logic [CW-1:0]   cd_wide;
  logic [7:0]      line_byte;
  logic            over_rise, status_change;
  logic            leave_over, leave_status, fire;

  function automatic logic [7:0] bcd_char(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : {4'h3, n};
  endfunction

  assign over_rise     = over & ~prev_over;
  assign status_change = start & ~over & ((score != last_score) | (count_down != last_cd));
  assign cd_wide       = CW'(count_down);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next         = state;
    leave_over   = 1'b0;
    leave_status = 1'b0;
    fire         = 1'b0;
    case (state)
      IDLE: begin
        if (over_pending) begin
          leave_over = 1'b1;
          next       = CONV;
        end else if (status_pending && rate_cnt == RATE_MAX) begin
          leave_status = 1'b1;
          next         = CONV;
        end
      end
      CONV: begin
        if (cd_work < 10'd10) next = SEND;
      end
      SEND: begin
        if (!uart.is_transmitting) begin
          fire = 1'b1;
          next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (uart.is_transmitting || guard_cnt == GW'(GUARD - 1)) next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!uart.is_transmitting) next = (idx == 4'd11) ? IDLE : SEND;
      end
      default: next = IDLE;
    endcase
  end

  // Byte selection from the snapshot; digits come from the finished conversion.
  always_comb begin
    line_byte = 8'h00;
    if (line_over) begin
      case (idx)
        4'd0:    line_byte = "O";
        4'd1:    line_byte = "V";
        4'd2:    line_byte = "E";
        4'd3:    line_byte = "R";
        4'd4:    line_byte = " ";
        4'd5:    line_byte = "S";
        4'd6:    line_byte = bcd_char(last_score[15:12]);
        4'd7:    line_byte = bcd_char(last_score[11:8]);
        4'd8:    line_byte = bcd_char(last_score[7:4]);
        4'd9:    line_byte = bcd_char(last_score[3:0]);
        4'd10:   line_byte = 8'h0D;
        4'd11:   line_byte = 8'h0A;
        default: line_byte = 8'h00;
      endcase
    end else begin
      case (idx)
        4'd0:    line_byte = "S";
        4'd1:    line_byte = bcd_char(last_score[15:12]);
        4'd2:    line_byte = bcd_char(last_score[11:8]);
        4'd3:    line_byte = bcd_char(last_score[7:4]);
        4'd4:    line_byte = bcd_char(last_score[3:0]);
        4'd5:    line_byte = " ";
        4'd6:    line_byte = "T";
        4'd7:    line_byte = bcd_char(h_dig);
        4'd8:    line_byte = bcd_char(t_dig);
        4'd9:    line_byte = bcd_char(cd_work[3:0]);
        4'd10:   line_byte = 8'h0D;
        4'd11:   line_byte = 8'h0A;
        default: line_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_over      <= 1'b0;
      over_pending   <= 1'b0;
      status_pending <= 1'b0;
      rate_cnt       <= RATE_MAX;
      last_score     <= '0;
      last_cd        <= '0;
      line_over      <= 1'b0;
      idx            <= '0;
      cd_work        <= '0;
      h_dig          <= '0;
      t_dig          <= '0;
      guard_cnt      <= '0;
      uart.transmit  <= 1'b0;
      uart.tx_byte   <= 8'h00;
      sent_count     <= 16'h0000;
    end else begin
      prev_over <= over;

      if (over_rise)       over_pending <= 1'b1;
      else if (leave_over) over_pending <= 1'b0;

      // The value that triggered a served line is the one snapshotted, so clearing wins here.
      if (over_rise || leave_status) status_pending <= 1'b0;
      else if (status_change)        status_pending <= 1'b1;

      if (leave_status)           rate_cnt <= '0;
      else if (rate_cnt != RATE_MAX) rate_cnt <= rate_cnt + RW'(1);

      if (leave_over || leave_status) begin
        last_score <= score;
        last_cd    <= count_down;
        line_over  <= leave_over;
        idx        <= 4'd0;
        h_dig      <= 4'd0;
        t_dig      <= 4'd0;
        cd_work    <= (cd_wide > CW'(999)) ? 10'd999 : cd_wide[9:0];
      end

      if (state == CONV) begin
        if (cd_work >= 10'd100) begin
          cd_work <= cd_work - 10'd100;
          h_dig   <= h_dig + 4'd1;
        end else if (cd_work >= 10'd10) begin
          cd_work <= cd_work - 10'd10;
          t_dig   <= t_dig + 4'd1;
        end
      end

      if (fire) begin
        uart.transmit <= 1'b1;
        uart.tx_byte  <= line_byte;
        guard_cnt     <= '0;
      end else begin
        uart.transmit <= 1'b0;
      end

      if (state == WAIT_HI && next == WAIT_HI) guard_cnt <= guard_cnt + GW'(1);

      if (state == WAIT_LO && !uart.is_transmitting) begin
        if (idx == 4'd11) sent_count <= sent_count + 16'd1;
        else              idx        <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_status_reporter.sv
// tb/tb_status_reporter.sv - randomized self-checking bench for status_reporter with a uart model
module tb_status_reporter;
  localparam int CD_W  = 10;
  localparam int RATE  = 1000;
  localparam int GUARD = 4;

  logic            clk = 1'b0;
  logic            reset, start, over;
  logic [15:0]     score;
  logic [CD_W-1:0] count_down;
  logic            busy;
  logic [15:0]     sent_count;

  status_reporter_if uif();

  status_reporter #(.CD_W(CD_W), .RATE_TICK(RATE), .GUARD(GUARD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .over       (over),
    .score      (score),
    .count_down (count_down),
    .uart       (uif.master),
    .busy       (busy),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  bit uart_on = 1'b1;
  int hold_len = 10;
  int hold_cnt = 0;
  int prev_pulse = -100;
  int proto_viol = 0;
  int exp_sent = 0;
  int last_start = 0;
  logic [7:0] pulse_q[$];
  int         pulse_t[$];

  // uart model and pulse monitor share one block so ordering within a cycle is fixed
  always @(posedge clk) begin
    #1;
    cycle++;
    if (uif.transmit === 1'b1) begin
      if (uif.is_transmitting === 1'b1 || cycle - prev_pulse < 2) proto_viol++;
      pulse_q.push_back(uif.tx_byte);
      pulse_t.push_back(cycle);
      prev_pulse = cycle;
      if (uart_on) hold_cnt = hold_len;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
    end
    uif.is_transmitting = (hold_cnt > 0);
  end

  function automatic logic [7:0] dch(input int n);
    return (n > 9) ? 8'h3F : 8'(48 + n);
  endfunction

  function automatic logic [95:0] exp_status(input logic [15:0] sc, input int cd);
    int c;
    c = (cd > 999) ? 999 : cd;
    return {"S", dch(int'(sc[15:12])), dch(int'(sc[11:8])), dch(int'(sc[7:4])), dch(int'(sc[3:0])),
            " ", "T", dch(c / 100), dch((c / 10) % 10), dch(c % 10), 8'h0D, 8'h0A};
  endfunction

  function automatic logic [95:0] exp_over(input logic [15:0] sc);
    return {"OVER S", dch(int'(sc[15:12])), dch(int'(sc[11:8])), dch(int'(sc[7:4])), dch(int'(sc[3:0])),
            8'h0D, 8'h0A};
  endfunction

  function automatic logic [95:0] pop_line();
    logic [95:0] v;
    v = '0;
    for (int i = 0; i < 12; i++) begin
      v = {v[87:0], pulse_q.pop_front()};
      void'(pulse_t.pop_front());
    end
    return v;
  endfunction

  task automatic wait_pulses(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (pulse_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (pulse_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; over = 1'b0; score = 16'h0000; count_down = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pulse_q.delete();
    pulse_t.delete();
    exp_sent = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (uif.transmit !== 1'b0) begin bad++; $display("FAIL reset_transmit got=%0b want=0", uif.transmit); end
    total++; if (uif.tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte got=%h want=00", uif.tx_byte); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (sent_count !== 16'h0000) begin bad++; $display("FAIL reset_sent_count got=%0d want=0", sent_count); end
    repeat (50) @(negedge clk);
    total++; if (pulse_q.size() != 0) begin bad++; $display("FAIL reset_quiet got=%0d pulses want=0", pulse_q.size()); end
  endtask

  task automatic test_basic_line();
    bit ok;
    logic [95:0] got;
    uart_on = 1'b1; hold_len = 10;
    score = 16'h0123; count_down = 10'd59; start = 1'b1;
    wait_pulses(12, 400, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL basic_timeout got=%0d pulses want=12", pulse_q.size());
    end else begin
      last_start = pulse_t[0];
      got = pop_line();
      total++; if (got !== exp_status(16'h0123, 59)) begin bad++; $display("FAIL basic_line got=%h want=%h", got, exp_status(16'h0123, 59)); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_last got=%0b want=1", busy); end
      wait_idle(40, ok);
      total++; if (!ok) begin bad++; $display("FAIL basic_busy_fall got=%0b want=0", busy); end
      exp_sent = 1;
      total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL basic_sent got=%0d want=%0d", sent_count, exp_sent); end
    end
  endtask

  task automatic test_rate_limit();
    bit ok;
    int t0;
    logic [95:0] got;
    count_down = 10'd58;
    repeat (20) @(negedge clk);
    count_down = 10'd57;
    wait_pulses(12, 1500, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rate_timeout got=%0d pulses want=12", pulse_q.size());
    end else begin
      t0 = pulse_t[0];
      got = pop_line();
      total++; if (got !== exp_status(16'h0123, 57)) begin bad++; $display("FAIL rate_line got=%h want=%h", got, exp_status(16'h0123, 57)); end
      total++; if (t0 - last_start < RATE) begin bad++; $display("FAIL rate_gap got=%0d want>=%0d", t0 - last_start, RATE); end
      last_start = t0;
      exp_sent++;
    end
    repeat (1500) @(negedge clk);
    total++; if (pulse_q.size() != 0) begin bad++; $display("FAIL rate_coalesce got=%0d extra pulses want=0", pulse_q.size()); end
    total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL rate_sent got=%0d want=%0d", sent_count, exp_sent); end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] sc;
    int cd;
    logic [95:0] got;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        sc = 16'h0A12; cd = 1023;
      end else begin
        sc = 16'($urandom_range(0, 65535));
        cd = int'($urandom_range(0, 1023));
      end
      if (sc == score && cd == int'(count_down)) cd = cd ^ 1;
      hold_len = int'($urandom_range(1, 12));
      score = sc; count_down = 10'(cd);
      wait_pulses(12, 2500, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL random_timeout it=%0d got=%0d pulses want=12", it, pulse_q.size());
      end else begin
        last_start = pulse_t[0];
        got = pop_line();
        total++; if (got !== exp_status(sc, cd)) begin bad++; $display("FAIL random_line it=%0d got=%h want=%h", it, got, exp_status(sc, cd)); end
        wait_idle(60, ok);
        exp_sent++;
        total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL random_sent it=%0d got=%0d want=%0d", it, sent_count, exp_sent); end
      end
    end
  endtask

  task automatic test_over_mid_status();
    bit ok;
    int t_last, t_over;
    logic [95:0] got;
    hold_len = 10;
    score = 16'h0450; count_down = 10'd321;
    wait_pulses(5, 2500, ok);
    over = 1'b1;
    wait_pulses(24, 1000, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL over_timeout got=%0d pulses want=24", pulse_q.size());
    end else begin
      t_last = pulse_t[11];
      t_over = pulse_t[12];
      got = pop_line();
      total++; if (got !== exp_status(16'h0450, 321)) begin bad++; $display("FAIL over_status_line got=%h want=%h", got, exp_status(16'h0450, 321)); end
      got = pop_line();
      total++; if (got !== exp_over(16'h0450)) begin bad++; $display("FAIL over_line got=%h want=%h", got, exp_over(16'h0450)); end
      total++; if (t_over - t_last > 60) begin bad++; $display("FAIL over_no_rate_wait got=%0d want<=60", t_over - t_last); end
      exp_sent += 2;
    end
    count_down = 10'd77;
    repeat (1500) @(negedge clk);
    total++; if (pulse_q.size() != 0) begin bad++; $display("FAIL over_quiet got=%0d pulses want=0", pulse_q.size()); end
    total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL over_sent got=%0d want=%0d", sent_count, exp_sent); end
    start = 1'b0; over = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_over_priority();
    bit ok;
    logic [95:0] got;
    start = 1'b1; over = 1'b1; score = 16'h0987;
    wait_pulses(12, 400, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL prio_timeout got=%0d pulses want=12", pulse_q.size());
    end else begin
      got = pop_line();
      total++; if (got !== exp_over(16'h0987)) begin bad++; $display("FAIL prio_line got=%h want=%h", got, exp_over(16'h0987)); end
      exp_sent++;
    end
    repeat (1200) @(negedge clk);
    total++; if (pulse_q.size() != 0) begin bad++; $display("FAIL prio_quiet got=%0d pulses want=0", pulse_q.size()); end
    start = 1'b0; over = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_line();
    bit ok;
    score = 16'h2222; count_down = 10'd5; start = 1'b1;
    wait_pulses(5, 2500, ok);
    total++; if (!ok) begin bad++; $display("FAIL midreset_timeout got=%0d pulses want=5", pulse_q.size()); end
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    total++; if (uif.transmit !== 1'b0) begin bad++; $display("FAIL midreset_transmit got=%0b want=0", uif.transmit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b want=0", busy); end
    total++; if (sent_count !== 16'h0000) begin bad++; $display("FAIL midreset_sent got=%0d want=0", sent_count); end
    @(negedge clk);
    reset = 1'b0;
    pulse_q.delete(); pulse_t.delete();
    exp_sent = 0;
    repeat (200) @(negedge clk);
    total++; if (pulse_q.size() != 0) begin bad++; $display("FAIL midreset_quiet got=%0d pulses want=0", pulse_q.size()); end
  endtask

  task automatic test_guard();
    bit ok;
    int nbad;
    logic [95:0] got;
    uart_on = 1'b0;
    score = 16'h0042; count_down = 10'd5; start = 1'b1;
    wait_pulses(12, 400, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL guard_timeout got=%0d pulses want=12", pulse_q.size());
    end else begin
      nbad = 0;
      for (int i = 1; i < 12; i++) if (pulse_t[i] - pulse_t[i-1] != GUARD + 2) nbad++;
      total++; if (nbad != 0) begin bad++; $display("FAIL guard_spacing got=%0d bad gaps (first gap %0d) want=0 gaps of %0d", nbad, pulse_t[1] - pulse_t[0], GUARD + 2); end
      got = pop_line();
      total++; if (got !== exp_status(16'h0042, 5)) begin bad++; $display("FAIL guard_line got=%h want=%h", got, exp_status(16'h0042, 5)); end
      wait_idle(40, ok);
      exp_sent++;
      total++; if (sent_count !== 16'(exp_sent)) begin bad++; $display("FAIL guard_sent got=%0d want=%0d", sent_count, exp_sent); end
    end
    uart_on = 1'b1;
  endtask

  task automatic test_protocol();
    total++; if (proto_viol != 0) begin bad++; $display("FAIL protocol got=%0d violations want=0", proto_viol); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; over = 1'b0; score = 16'h0000; count_down = '0;
    test_reset();
    test_basic_line();
    test_rate_limit();
    test_random();
    test_over_mid_status();
    test_over_priority();
    test_reset_mid_line();
    test_guard();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_reporter.md
Name: status_reporter

Overview:
- UART transmit-side companion to the game control/command decoder: formats live game status as fixed-length ASCII lines and drives the byte-level `uart` transmitter through its `transmit` / `tx_byte` / `is_transmitting` interface.
- Sits between the game state (score, countdown, start/over flags) and the shared `uart` instance.
- Sends a status line when score or countdown changes, rate-limited, and a one-shot game-over line.

Parameters:
- CD_W, 8: width of count_down input (binary seconds).
- RATE_TICK, 10_000_000: minimum clk cycles between starts of consecutive status lines.
- GUARD, 4: max cycles to wait for is_transmitting to rise after a transmit pulse before proceeding anyway.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  game running.
- over  in  1  game finished.
- score  in  16  4 BCD digits, digit 3 (most significant) at [15:12].
- count_down  in  CD_W  remaining seconds, binary.
- is_transmitting  in  1  from uart; high while a byte is shifting out.
- transmit  out  1  one-cycle pulse to start a byte.
- tx_byte  out  8  byte presented with transmit; held stable until the next pulse.
- busy  out  1  high whenever state != IDLE.
- sent_count  out  16  completed lines since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset values: transmit=0, tx_byte=0, busy=0, sent_count=0, FSM=IDLE.
  - Reset clears both pending flags, the snapshots, prev_over, and the rate counter; the rate counter resets to the RATE_TICK value, so the first line is not delayed.
  - Reset mid-line: abort next edge with no further pulses. A byte already inside the uart is not our concern.
- Line formats, both exactly 12 bytes:
  - STATUS: 'S' d3 d2 d1 d0 ' ' 'T' h t o CR LF. Example: "S0123 T059\r\n".
  - OVER: 'O' 'V' 'E' 'R' ' ' 'S' d3 d2 d1 d0 CR LF.
  - Score nibble 0-9 -> 0x30+n; nibble >9 -> '?' (0x3F).
  - count_down >999 displays "999".
- Triggers:
  - status_pending sets when start & ~over and (score != last_score or count_down != last_cd). The last_* registers are updated at snapshot time.
  - over_pending sets on the over rising edge (over & ~prev_over).
  - Setting over_pending clears status_pending.
  - Changes arriving during a line coalesce into one further line carrying the latest values.
- Rate limit:
  - rate_cnt saturates at RATE_TICK and is cleared when a STATUS line starts.
  - A STATUS line may start only when rate_cnt == RATE_TICK.
  - OVER bypasses the rate limit.
- FSM states: IDLE, CONV, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - If over_pending: select OVER, go to CONV.
  - Else if status_pending and rate OK: select STATUS, go to CONV.
  - On leaving IDLE: snapshot score and count_down into last_*, clear the pending flag being served, set byte index = 0.
- CONV: BCD conversion by repeated subtraction, one subtract per cycle.
  - Subtract 100 while ≥100 to form the hundreds digit, then 10 while ≥10 to form tens; the remainder is ones.
  - Saturate first if the value is >999.
  - Latency ≤ 20 cycles. Go to SEND.
- SEND: when is_transmitting==0, drive tx_byte = line[index] and pulse transmit for 1 cycle, then go to WAIT_HI.
- WAIT_HI: wait for is_transmitting=1, or GUARD cycles elapsed, then go to WAIT_LO.
- WAIT_LO: wait for is_transmitting=0.
  - index==11: sent_count++, go to IDLE.
  - Otherwise: index++, go to SEND.
- Never two transmit pulses closer than 2 cycles; never a pulse while is_transmitting=1.
- Simultaneous events:
  - An over rising edge in the same cycle as a status change: OVER wins.
  - A STATUS line in progress completes before OVER is sent.
  - A change in the same cycle as the snapshot is caught on the next comparison.

Test Plan:
- Reset, then start=1, score=16'h0123, count_down=59, uart model holding is_transmitting high 10 cycles per byte -> exactly 12 pulses with bytes "S0123 T059\r\n"; sent_count=1; busy falls after the 12th byte.
- count_down 59->58->57 within RATE_TICK (set to 1000) -> only one further line, "S0123 T057\r\n", starting ≥1000 cycles after the previous line start.
- over rises mid-STATUS line with score=16'h0450 -> STATUS line completes, then "OVER S0450\r\n" follows with no rate wait; no STATUS lines are sent after it.
- CD_W=10, count_down=1023 -> digits "999". Score nibble 0xA -> '?' in its position.
- Assert reset at byte 5 of a line -> transmit=0 and busy=0 on the next edge, sent_count=0, no pulses until a new trigger.
- is_transmitting held low (uart model never responds) with GUARD=4 -> pulses spaced exactly GUARD+2 cycles apart, 12 bytes total, sent_count increments.
